// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage sitting directly upstream of decode.
// Issues one fetch at a time on an SRAM-like bus, tracks the response, and
// presents {pc, exc, badVAddr, bd} to decode over the valid/allowin handshake.
// Handles branch redirects (delay-slot aware), exception cancel, AdEL on
// misaligned fetch addresses, and silently drops stale responses.
// Optional build macro FETCH_PERF_EN adds perf_req_cnt / perf_stall_cnt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'hbfc00000,
    parameter logic [31:0] EXC_VECTOR = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        allowin_i,
    output logic        valid_o,
    output logic        ready_go_o,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        d_inst_data_ok,
    input  logic        br_i,
    input  logic [31:0] br_target_i,
    input  logic        d_jump_i,
    input  logic        cancel_i,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    output logic [31:0] pc_o,
    output logic [4:0]  exc_o,
    output logic [31:0] badVAddr_o,
    output logic [31:0] bd_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] br_target;
    logic        br_pending;
    logic        discard;

    logic        req_fire;
    logic        misaligned;
    logic        fill;
    logic        resp_live;
    logic [31:0] next_pc;

    assign inst_req       = (state == S_REQ) && (fetch_pc[1:0] == 2'b00);
    assign inst_addr      = fetch_pc;
    assign req_fire       = inst_req && inst_addr_ok;
    assign misaligned     = (state == S_REQ) && (fetch_pc[1:0] != 2'b00);
    // A new instruction enters the F slot this cycle (fetched or faulting).
    assign fill           = req_fire || misaligned;
    assign resp_live      = (state == S_WAIT) && inst_data_ok && !discard;
    assign d_inst_data_ok = resp_live && !cancel_i;
    assign ready_go_o     = valid_o && ((state == S_HOLD) || resp_live);
    // A pending redirect (branch seen before its delay slot was fetched)
    // takes effect right after the delay slot is accepted.
    assign next_pc        = br_pending ? br_target : fetch_pc + 32'd4;

    // Fetch FSM, F-slot payload registers and branch redirect bookkeeping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            br_target  <= 32'd0;
            br_pending <= 1'b0;
            discard    <= 1'b0;
            valid_o    <= 1'b0;
            pc_o       <= 32'd0;
            exc_o      <= 5'd0;
            badVAddr_o <= 32'd0;
            bd_o       <= 32'd0;
        end else if (cancel_i) begin
            valid_o    <= 1'b0;
            br_pending <= 1'b0;
            fetch_pc   <= EXC_VECTOR;
            // A response still owed by the bus must be swallowed when it lands.
            if (req_fire || ((state == S_WAIT) && !inst_data_ok)) begin
                discard <= 1'b1;
                state   <= S_WAIT;
            end else begin
                discard <= 1'b0;
                state   <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (req_fire) begin
                        pc_o       <= fetch_pc;
                        valid_o    <= 1'b1;
                        bd_o       <= {31'd0, d_jump_i};
                        exc_o      <= 5'd0;
                        badVAddr_o <= 32'd0;
                        fetch_pc   <= next_pc;
                        state      <= S_WAIT;
                    end else if (misaligned) begin
                        pc_o       <= fetch_pc;
                        valid_o    <= 1'b1;
                        bd_o       <= {31'd0, d_jump_i};
                        exc_o      <= 5'd4;
                        badVAddr_o <= fetch_pc;
                        fetch_pc   <= next_pc;
                        state      <= S_HOLD;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= S_REQ;
                        end else if (allowin_i) begin
                            valid_o <= 1'b0;
                            state   <= S_REQ;
                        end else begin
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (allowin_i) begin
                        valid_o <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            // If the delay slot is already in F (or entering now) the next
            // fetch goes straight to the target; otherwise wait for the slot.
            if (br_i) begin
                br_target <= br_target_i;
                if (valid_o || fill) begin
                    fetch_pc   <= br_target_i;
                    br_pending <= 1'b0;
                end else begin
                    br_pending <= 1'b1;
                end
            end else if (fill) begin
                br_pending <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Accepted-request and F-stall cycle counters; both wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_req_cnt   <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (req_fire) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (valid_o && !ready_go_o) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
